// File: rtl/cla_pkg.sv
// Shared constants, stage-register control struct and configuration check for cla_pipe_adder.
package cla_pkg;

    localparam int unsigned CLA_WIDTH  = 32;
    localparam int unsigned CLA_GROUP  = 4;
    localparam int unsigned CLA_STAGES = 2;

    // Per-stage control state; the data part lives in the stage blocks since its width varies.
    typedef struct packed {
        logic v;
        logic c;
        logic ovf;
    } stage_ctrl_t;

    function automatic bit cla_cfg_ok(input int unsigned width, input int unsigned group,
                                      input int unsigned stages);
        return (stages * group != 0) && (width % (stages * group) == 0);
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead block: every internal carry is a flat function of
// the per-bit propagate/generate terms and the group carry-in.
module cla_group #(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             c_i,
    output logic [GROUP-1:0] s_o,
    output logic             c_o
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   carry;
    logic             acc;
    logic             prod;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    always_comb begin
        carry    = '0;
        acc      = 1'b0;
        prod     = 1'b1;
        carry[0] = c_i;
        for (int j = 1; j <= GROUP; j++) begin
            acc  = 1'b0;
            prod = 1'b1;
            // Walk down from bit j-1: g[m] counts only if all higher bits propagate.
            for (int m = j - 1; m >= 0; m--) begin
                acc  = acc | (g[m] & prod);
                prod = prod & p[m];
            end
            carry[j] = acc | (prod & c_i);
        end
    end

    assign s_o = p ^ carry[GROUP-1:0];
    assign c_o = carry[GROUP];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder with valid/ready on both sides; one slice per stage.
// Optional subtract support (sub_i port) is enabled by defining CLA_PIPE_SUB_EN.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = CLA_WIDTH,
    parameter int unsigned GROUP  = CLA_GROUP,
    parameter int unsigned STAGES = CLA_STAGES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
`ifdef CLA_PIPE_SUB_EN
    input  logic             sub_i,
`endif
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int unsigned SW = WIDTH / STAGES;
    localparam int unsigned NG = SW / GROUP;

    if (!cla_cfg_ok(WIDTH, GROUP, STAGES)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*GROUP");
    end

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

`ifdef CLA_PIPE_SUB_EN
    assign b_eff = sub_i ? ~b_i : b_i;
    assign c_eff = sub_i ? 1'b1 : carry_i;
`else
    assign b_eff = b_i;
    assign c_eff = carry_i;
`endif

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        // mix holds finished sum slices below slice i and untouched operand A slices above.
        logic [WIDTH-1:0] mix_in;
        logic [WIDTH-1:0] mix_d;
        logic [WIDTH-1:0] mix_q;
        logic [SW-1:0]    a_sl;
        logic [SW-1:0]    b_sl;
        logic [SW-1:0]    s_sl;
        logic [NG:0]      gc;
        logic             c_in;
        logic             v_in;
        logic             ovf;
        logic             en;
        stage_ctrl_t      ctrl_d;
        stage_ctrl_t      ctrl_q;

        if (i == 0) begin : g_in
            assign mix_in = a_i;
            assign b_sl   = b_eff[SW-1:0];
            assign c_in   = c_eff;
            assign v_in   = valid_i;
        end else begin : g_in
            assign mix_in = g_stage[i-1].mix_q;
            assign b_sl   = g_stage[i-1].g_fwd.b_q[i*SW +: SW];
            assign c_in   = g_stage[i-1].ctrl_q.c;
            assign v_in   = g_stage[i-1].ctrl_q.v;
        end

        // Operand B slices still to be consumed by later stages.
        if (i < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:(i+1)*SW] b_d;
            logic [WIDTH-1:(i+1)*SW] b_q;

            if (i == 0) begin : g_src
                assign b_d = b_eff[WIDTH-1:SW];
            end else begin : g_src
                assign b_d = g_stage[i-1].g_fwd.b_q[WIDTH-1:(i+1)*SW];
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    b_q <= '0;
                end else if (en) begin
                    b_q <= b_d;
                end
            end
        end

        if (i == STAGES - 1) begin : g_en
            assign en = ready_i | ~ctrl_q.v;
        end else begin : g_en
            assign en = ~ctrl_q.v | g_stage[i+1].en;
        end

        assign a_sl  = mix_in[i*SW +: SW];
        assign gc[0] = c_in;

        for (genvar g = 0; g < NG; g++) begin : g_grp
            cla_group #(
                .GROUP (GROUP)
            ) u_grp (
                .a_i (a_sl[g*GROUP +: GROUP]),
                .b_i (b_sl[g*GROUP +: GROUP]),
                .c_i (gc[g]),
                .s_o (s_sl[g*GROUP +: GROUP]),
                .c_o (gc[g+1])
            );
        end

        always_comb begin
            mix_d              = mix_in;
            mix_d[i*SW +: SW]  = s_sl;
            ovf                = (a_sl[SW-1] == b_sl[SW-1]) && (s_sl[SW-1] != a_sl[SW-1]);
            ctrl_d.v           = v_in;
            ctrl_d.c           = gc[NG];
            ctrl_d.ovf         = (i == STAGES - 1) ? ovf : 1'b0;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                ctrl_q <= '0;
                mix_q  <= '0;
            end else if (en) begin
                ctrl_q <= ctrl_d;
                mix_q  <= mix_d;
            end
        end
    end

    assign ready_o    = g_stage[0].en;
    assign valid_o    = g_stage[STAGES-1].ctrl_q.v;
    assign sum_o      = g_stage[STAGES-1].mix_q;
    assign carry_o    = g_stage[STAGES-1].ctrl_q.c;
    assign overflow_o = g_stage[STAGES-1].ctrl_q.ovf;

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder for the datapath: a WIDTH-bit add split into STAGES slices, each slice built from GROUP-bit lookahead groups, with the inter-slice carry registered between stages. A valid/ready handshake on both sides provides full throughput and backpressure. It is the wide, timing-closed successor to the single 4-bit lookahead adder and serves the ALU and address-generation paths, where a flat 32/64-bit add limits fmax.

## Interface
- WIDTH, 32: operand and sum width; must be a multiple of STAGES*GROUP
- GROUP, 4: bits per lookahead group inside a slice
- STAGES, 2: pipeline stages; slice width SW = WIDTH/STAGES
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- a_i  in  WIDTH  operand A
- b_i  in  WIDTH  operand B
- carry_i  in  1  carry-in to bit 0
- valid_i  in  1  input beat valid
- ready_o  out  1  block accepts the beat this cycle
- sum_o  out  WIDTH  result
- carry_o  out  1  carry-out of MSB
- overflow_o  out  1  signed overflow
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts the result

## Operation
- Pipeline registers R1..RS each hold: valid bit v_k, completed sum slices 0..k-1, the carry out of slice k-1, and operand slices k..STAGES-1.
- Stage 1 adds slice 0 of a_i/b_i with carry_i. Stage k (k>1) adds slice k-1 of the carried operands using the carry registered in R(k-1).
- Within a slice: per-bit P = a^b, G = a&b; GROUP-bit lookahead carries; group carries ripple across the SW/GROUP groups within the slice.
- overflow_o is computed in the last stage: (a_msb == b_msb) && (sum_msb != a_msb), using the effective b.
- Advance enables: en_S = ready_i | !v_S; en_k = !v_k | en_(k+1); ready_o = en_1. Rk loads when en_k is high. Data is held otherwise.
- Accepting a beat requires valid_i && ready_o. Results are produced strictly in acceptance order. There is no drop and no duplication.
- Outputs are driven directly from RS: valid_o = v_S.

## Timing
- Reset: every v_k = 0, every data register = 0. Therefore valid_o = 0, sum_o = 0, carry_o = 0, overflow_o = 0, and ready_o = 1. Reset takes effect immediately because it is asynchronous.
- Latency: a beat accepted on edge n appears on valid_o after edge n+STAGES-1, i.e. STAGES registered stages. With ready_i held high, throughput is 1 beat per cycle.
- Backpressure:
  - While valid_o && !ready_i, sum_o, carry_o and overflow_o are held stable.
  - ready_o falls combinationally once every stage is full.
- Simultaneous accept and release on a full pipe with ready_i = 1: both occur in the same cycle, and there is no bubble.
- Reset mid-operation: all in-flight beats are discarded. No stale result is presented after reset deasserts.
- ready_o depends combinationally on ready_i through the en_k chain. There is no combinational path from valid_i to ready_o.

## Configuration
- CLA_PIPE_SUB_EN defined:
  - Adds port sub_i (in, 1), captured with the beat.
  - sub_i = 1: the block computes a - b as a + ~b + 1. carry_i is ignored, and carry_o = 1 means no borrow.
  - overflow_o uses ~b as the effective b.
- CLA_PIPE_SUB_EN undefined: no sub_i port; the block is add only.

## Structure
- The shared package cla_pkg holds:
  - the default constants CLA_WIDTH, CLA_GROUP and CLA_STAGES;
  - the elaboration-time legality check (WIDTH % (STAGES*GROUP) == 0);
  - the stage-register struct typedef.
- One sub-module, cla_group: a combinational GROUP-bit lookahead block with P/G, carry-in, sum and carry-out. It is instantiated SW/GROUP times per slice via generate.

## Test plan
Configuration for all scenarios: WIDTH = 32, GROUP = 4, STAGES = 2.
- Reset: pulse rst_i -> valid_o = 0, sum_o = 0, carry_o = 0, overflow_o = 0, ready_o = 1, with the async effect seen before the next clock edge.
- Full-width carry propagation: a = 0xFFFF_FFFF, b = 0x1, carry_i = 0 -> sum_o = 0x0000_0000, carry_o = 1, overflow_o = 0, valid_o two edges after acceptance.
- Back-to-back beats:
  - 0x7FFF_FFFF + 0x1 -> 0x8000_0000, overflow_o = 1, carry_o = 0.
  - 0x0000_FFFF + 0x1 -> 0x0001_0000, carry crossing the slice boundary.
  - Results appear on consecutive cycles.
- Backpressure: hold ready_i = 0 for 4 cycles while issuing 3 beats -> ready_o falls after 2 beats accepted; sum_o is stable throughout; after release, all beats emerge in order with none lost.
- Reset with 2 beats in flight -> valid_o drops at once; no output appears after release until a new beat is accepted.
- With CLA_PIPE_SUB_EN:
  - sub_i = 1, a = 5, b = 7 -> 0xFFFF_FFFE, carry_o = 0.
  - a = 7, b = 5 -> 0x0000_0002, carry_o = 1.
  - a = 0x8000_0000, b = 1 -> 0x7FFF_FFFF, overflow_o = 1.
